// File: rtl/ks_pkg.sv
// Shared constants, FSM state type and sizing helper for the multi-precision
// Kogge-Stone adder family.
package ks_pkg;

   localparam int KS_W = 16;

   typedef enum logic [0:0] {
      S_FIRST = 1'b0,
      S_MID   = 1'b1
   } ks_state_e;

   // Narrowest word-index counter that can address every word of an operand.
   function automatic int ks_idx_w(input int words);
      int w;
      w = 1;
      while ((1 << w) < words) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/kogg_stone.sv
// 16-bit Kogge-Stone parallel-prefix adder, no carry in or out.
module kogg_stone
   import ks_pkg::*;
(
   input  logic [KS_W-1:0] a,
   input  logic [KS_W-1:0] b,
   output logic [KS_W-1:0] sum
);

   logic [KS_W-1:0] g0_s, p0_s, g1_s, p1_s, g2_s, p2_s, g3_s, p3_s, g4_s, p4_s;

   // Each level combines spans of distance 1,2,4,8; shifted-in g=0/p=1 are neutral.
   assign g0_s = a & b;
   assign p0_s = a ^ b;
   assign g1_s = g0_s | (p0_s & {g0_s[KS_W-2:0], 1'b0});
   assign p1_s = p0_s & {p0_s[KS_W-2:0], 1'b1};
   assign g2_s = g1_s | (p1_s & {g1_s[KS_W-3:0], 2'b00});
   assign p2_s = p1_s & {p1_s[KS_W-3:0], 2'b11};
   assign g3_s = g2_s | (p2_s & {g2_s[KS_W-5:0], 4'h0});
   assign p3_s = p2_s & {p2_s[KS_W-5:0], 4'hF};
   assign g4_s = g3_s | (p3_s & {g3_s[KS_W-9:0], 8'h00});
   assign p4_s = p3_s & {p3_s[KS_W-9:0], 8'hFF};

   assign sum = p0_s ^ {g4_s[KS_W-2:0], 1'b0};

endmodule

// File: rtl/ks_carry_add16.sv
// 16-bit add with carry in and carry out, built from two carry-less
// Kogge-Stone adders.
module ks_carry_add16
   import ks_pkg::*;
(
   input  logic [KS_W-1:0] a,
   input  logic [KS_W-1:0] b,
   input  logic            cin,
   output logic [KS_W-1:0] sum,
   output logic            cout
);

   logic [KS_W-1:0] s1_s;
   logic            c1_s;
   logic            c2_s;

   kogg_stone u_add_ab (
      .a   (a),
      .b   (b),
      .sum (s1_s)
   );

   kogg_stone u_add_cin (
      .a   (s1_s),
      .b   ({{(KS_W-1){1'b0}}, cin}),
      .sum (sum)
   );

   // A wrapped first add and a cin ripple through 0xFFFF are mutually exclusive.
   assign c1_s = (s1_s < a);
   assign c2_s = cin & (s1_s == {KS_W{1'b1}});
   assign cout = c1_s | c2_s;

endmodule

// File: rtl/ks_mp_adder.sv
// Streaming multi-precision adder: one 16-bit word pair in, one registered
// sum word out, LSW first, with inter-word carry held in a register.
module ks_mp_adder
   import ks_pkg::*;
#(
   parameter int WORDS = 4,
   parameter int IDX_W = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clear,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [KS_W-1:0] a_word,
   input  logic [KS_W-1:0] b_word,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [KS_W-1:0] sum_word,
   output logic            out_first,
   output logic            out_last,
   output logic            carry_out
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   ks_state_e       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic            carry_q, carry_d;
   logic            out_valid_q, out_valid_d;
   logic [KS_W-1:0] sum_q, sum_d;
   logic            first_q, first_d;
   logic            last_q, last_d;
   logic            cout_q, cout_d;

   logic            accept_s;
   logic            cin_s;
   logic [KS_W-1:0] word_sum_s;
   logic            word_carry_s;

   assign in_ready = !out_valid_q || out_ready;
   assign accept_s = in_valid && in_ready && !clear;
   assign cin_s    = (state_q == S_FIRST) ? 1'b0 : carry_q;

   ks_carry_add16 u_word_add (
      .a    (a_word),
      .b    (b_word),
      .cin  (cin_s),
      .sum  (word_sum_s),
      .cout (word_carry_s)
   );

   // Next-state: clear beats accept; accept reloads the output register.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      carry_d     = carry_q;
      out_valid_d = out_valid_q;
      sum_d       = sum_q;
      first_d     = first_q;
      last_d      = last_q;
      cout_d      = cout_q;
      if (clear) begin
         state_d     = S_FIRST;
         idx_d       = {IDX_W{1'b0}};
         carry_d     = 1'b0;
         out_valid_d = 1'b0;
         sum_d       = {KS_W{1'b0}};
         first_d     = 1'b0;
         last_d      = 1'b0;
         cout_d      = 1'b0;
      end else if (accept_s) begin
         out_valid_d = 1'b1;
         sum_d       = word_sum_s;
         first_d     = (idx_q == {IDX_W{1'b0}});
         last_d      = 1'b0;
         cout_d      = 1'b0;
         case (state_q)
            S_FIRST: begin
               if (WORDS == 1) begin
                  last_d = 1'b1;
                  cout_d = word_carry_s;
               end else begin
                  carry_d = word_carry_s;
                  idx_d   = IDX_ONE;
                  state_d = S_MID;
               end
            end
            S_MID: begin
               if (idx_q == LAST_IDX) begin
                  last_d  = 1'b1;
                  cout_d  = word_carry_s;
                  carry_d = 1'b0;
                  idx_d   = {IDX_W{1'b0}};
                  state_d = S_FIRST;
               end else begin
                  carry_d = word_carry_s;
                  idx_d   = idx_q + IDX_ONE;
               end
            end
            default: begin
               state_d = S_FIRST;
               idx_d   = {IDX_W{1'b0}};
               carry_d = 1'b0;
            end
         endcase
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // State, carry and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_FIRST;
         idx_q       <= {IDX_W{1'b0}};
         carry_q     <= 1'b0;
         out_valid_q <= 1'b0;
         sum_q       <= {KS_W{1'b0}};
         first_q     <= 1'b0;
         last_q      <= 1'b0;
         cout_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         carry_q     <= carry_d;
         out_valid_q <= out_valid_d;
         sum_q       <= sum_d;
         first_q     <= first_d;
         last_q      <= last_d;
         cout_q      <= cout_d;
      end
   end

   assign out_valid = out_valid_q;
   assign sum_word  = sum_q;
   assign out_first = first_q;
   assign out_last  = last_q;
   assign carry_out = cout_q;

endmodule
